// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: shared types for the universal shift engine.
//   mode_e : operation select driven on univ_shift_engine.mode
//   fsm_e  : PISO transfer state
package univ_shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    PIPO = 3'd1,
    SIPO = 3'd2,
    SISO = 3'd3,
    PISO = 3'd4,
    ROT  = 3'd5,
    ASHR = 3'd6,
    RSVD = 3'd7
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fsm_e;

endpackage

// File: rtl/univ_shift_counter.sv
// shift_counter: counts shifts within a word and flags word completion.
//   clk, rst : clock, async active-high reset
//   enb      : clock enable, low holds the count
//   clr      : restart the word (count -> 0, no terminal count)
//   inc      : one shift happened this cycle
//   cnt      : shifts completed in the current word (0..NSH-1)
//   tc       : NSH-th shift happens this cycle; count reloads to 0
module shift_counter #(
  parameter int NSH = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc  = enb & inc & ~clr & (cnt_q == CW'(NSH - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (enb) begin
      if (clr)      cnt_d = '0;
      else if (inc) cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/univ_shift_engine.sv
// univ_shift_engine: DW-bit universal register with SW-bit serial lanes.
// Modes: hold, parallel load, serial-in/parallel-out with word capture,
// serial-in/serial-out, parallel-in/serial-out with load handshake,
// rotate, and arithmetic right / logical left shift.
//   clk, rst           : clock, async active-high reset
//   enb                : clock enable; low freezes all state
//   mode, dir          : operation select, 0 = toward MSB, 1 = toward LSB
//   load_vld/load_rdy  : PISO parallel-load handshake
//   par_in, ser_in     : parallel / serial data in
//   par_out, ser_out   : register (SIPO: last captured word) / serial lane out
//   word_done          : pulses in the cycle of the NSH-th shift
//   busy               : PISO transfer in progress
// Optional build macro UNIV_SHIFT_PARITY_EN adds parity_out, the registered
// XOR of par_out.
module univ_shift_engine
  import univ_shift_pkg::*;
#(
  parameter int DW = 8,
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic [2:0]    mode,
  input  logic          dir,
  input  logic          load_vld,
  output logic          load_rdy,
  input  logic [DW-1:0] par_in,
  input  logic [SW-1:0] ser_in,
  output logic [DW-1:0] par_out,
  output logic [SW-1:0] ser_out,
  output logic          word_done,
  output logic          busy
`ifdef UNIV_SHIFT_PARITY_EN
  ,
  output logic          parity_out
`endif
);

  localparam int NSH = DW / SW;
  localparam int CW  = $clog2(NSH + 1);

  if (DW % SW != 0) begin : g_dw_chk
    $error("univ_shift_engine: DW must be a multiple of SW");
  end

  mode_e         m, mode_q, mode_d;
  fsm_e          state_q, state_d;
  logic [DW-1:0] sr_q, sr_d, cap_q, cap_d;
  logic [DW-1:0] sh_v, rot_v, ashr_v;
  logic [CW-1:0] cnt;
  logic          tc, abort, load, cnt_inc, cnt_clr;

  assign m = mode_e'(mode);

  // Shift amounts are constants, so these are plain wiring; using shifts
  // rather than slices keeps DW == SW legal.
  assign sh_v   = dir ? ((sr_q >> SW) | (DW'(ser_in) << (DW - SW)))
                      : ((sr_q << SW) | DW'(ser_in));
  assign rot_v  = dir ? ((sr_q >> SW) | (sr_q << (DW - SW)))
                      : ((sr_q << SW) | (sr_q >> (DW - SW)));
  assign ashr_v = dir ? DW'($signed(sr_q) >>> SW) : (sr_q << SW);

  // Leaving a mode mid-word drops the partial word: the counter restarts
  // and the PISO transfer is abandoned, but the register keeps its bits.
  assign abort   = (m != mode_q) && ((cnt != '0) || (state_q == SHIFT));
  assign load    = enb & (m == PISO) & (state_q == IDLE) & load_vld;
  assign cnt_inc = enb & ((m == SIPO) | (m == SISO) | (m == ROT) | (m == ASHR) |
                          ((m == PISO) & (state_q == SHIFT)));
  assign cnt_clr = enb & (abort | load);

  shift_counter #(.NSH(NSH), .CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .enb (enb),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .tc  (tc)
  );

  always_comb begin
    sr_d    = sr_q;
    cap_d   = cap_q;
    state_d = state_q;
    mode_d  = mode_q;
    if (enb) begin
      mode_d  = m;
      state_d = IDLE;
      case (m)
        PIPO:       sr_d = par_in;
        SIPO, SISO: sr_d = sh_v;
        ROT:        sr_d = rot_v;
        ASHR:       sr_d = ashr_v;
        PISO: begin
          if (state_q == IDLE) begin
            if (load_vld) begin
              sr_d    = par_in;
              state_d = SHIFT;
            end
          end else begin
            sr_d    = sh_v;
            state_d = tc ? IDLE : SHIFT;
          end
        end
        default: ;
      endcase
      if ((m == SIPO) && tc) cap_d = sr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cap_q   <= '0;
      state_q <= IDLE;
      mode_q  <= HOLD;
    end else begin
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  assign ser_out   = dir ? sr_q[SW-1:0] : sr_q[DW-1 -: SW];
  assign par_out   = (m == SIPO) ? cap_q : sr_q;
  assign busy      = (state_q == SHIFT);
  assign load_rdy  = rst | (enb & (state_q == IDLE));
  assign word_done = tc & ~rst;

`ifdef UNIV_SHIFT_PARITY_EN
  logic parity_q, parity_d;

  // In SIPO par_out is the capture register, so this only moves after a capture.
  assign parity_d   = enb ? ^par_out : parity_q;
  assign parity_out = parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

endmodule
